// File: rtl/lfsr_hexdisp.sv
// Fibonacci LFSR test-pattern source with seed load, run/step modes, prescaler,
// all-zero lockup recovery, period measurement and hex seven-segment digit outputs.
module lfsr_hexdisp #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
  parameter int unsigned      DIV   = 1,
  parameter int unsigned      NDIG  = (WIDTH + 3) / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic              load,
  input  logic [WIDTH-1:0]  seed,
  output logic [WIDTH-1:0]  q,
  output logic              lockup,
  output logic [WIDTH-1:0]  period,
  output logic              period_valid,
  output logic [NDIG*8-1:0] seg
);

  localparam logic [15:0]      DivM1 = 16'(DIV - 1);
  localparam logic [WIDTH-1:0] OneW  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             lockup_q, lockup_d;
  logic [15:0]      presc_q, presc_d;
  logic             step_prev_q;
  logic [1:0]       mode_prev_q;

  logic [WIDTH-1:0] q_nxt;
  logic [15:0]      presc_base;
  logic             step_en;

  assign q_nxt = {^(q_q & TAPS), q_q[WIDTH-1:1]};

  // Step enable and prescaler; a mode change restarts the count from zero.
  always_comb begin
    step_en    = 1'b0;
    presc_d    = '0;
    presc_base = (mode != mode_prev_q) ? 16'd0 : presc_q;
    case (mode)
      2'b01: begin
        if (presc_base == DivM1) begin
          step_en = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_base + 16'd1;
        end
      end
      2'b10:   step_en = step & ~step_prev_q;
      default: step_en = 1'b0;
    endcase
  end

  always_comb begin
    q_d            = q_q;
    seed_d         = seed_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    lockup_d       = lockup_q;
    if (load) begin
      if (seed == '0) begin
        q_d      = OneW;
        seed_d   = OneW;
        lockup_d = 1'b1;
      end else begin
        q_d      = seed;
        seed_d   = seed;
        lockup_d = 1'b0;
      end
      cnt_d          = '0;
      period_valid_d = 1'b0;
    end else if (q_q == '0) begin
      q_d      = OneW;
      lockup_d = 1'b1;
    end else if (step_en) begin
      q_d = q_nxt;
      // A saturated counter freezes measurement until the next load or reset.
      if (cnt_q != '1) begin
        if (q_nxt == seed_q) begin
          period_d       = cnt_q + OneW;
          period_valid_d = 1'b1;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + OneW;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q            <= OneW;
      seed_q         <= OneW;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      lockup_q       <= 1'b0;
      presc_q        <= '0;
      step_prev_q    <= 1'b0;
      mode_prev_q    <= 2'b00;
    end else begin
      q_q            <= q_d;
      seed_q         <= seed_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      lockup_q       <= lockup_d;
      presc_q        <= load ? 16'd0 : presc_d;
      step_prev_q    <= step;
      mode_prev_q    <= mode;
    end
  end

  assign q            = q_q;
  assign lockup       = lockup_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  logic [NDIG*4-1:0] q_pad;

  always_comb begin
    q_pad            = '0;
    q_pad[WIDTH-1:0] = q_q;
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    assign seg[8*i +: 8] = hex7(q_pad[4*i +: 4]);
  end

endmodule
